// File: rtl/bmcp_recv_fifo.sv
// Receive side of the MCP word-transfer synchronizer: toggle synchronizer, capture of the held
// sender word into a show-ahead FIFO, ack toggle back to the sender and sticky protocol-error flag.
module bmcp_recv_fifo #(
   parameter int DW          = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       bclk,
   input  logic                       brst,
   input  logic                       a_tog,
   input  logic [DW-1:0]              adata,
   output logic                       b_ack,
   output logic [DW-1:0]              bdata,
   output logic                       bvalid,
   input  logic                       bready,
   output logic [$clog2(DEPTH):0]     bcount,
   output logic                       b_busy,
   output logic                       b_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_q;
   logic                   r_ack;
   logic                   r_pending;
   logic                   r_err;
   logic [PW-1:0]          r_wr;
   logic [PW-1:0]          r_rd;
   logic [DW-1:0]          r_mem [DEPTH];

   logic w_sync;
   logic w_en;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_space;
   logic w_req;
   logic w_push;

   assign w_sync  = r_sync[SYNC_STAGES-1];
   assign w_en    = w_sync ^ r_q;
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && bready;
   // A pop in the same cycle frees the slot the push needs.
   assign w_space = !w_full || w_pop;
   assign w_req   = w_en || r_pending;
   assign w_push  = w_req && w_space;

   always_ff @(posedge bclk or posedge brst) begin
      if (brst) begin
         r_sync    <= '0;
         r_q       <= 1'b0;
         r_ack     <= 1'b0;
         r_pending <= 1'b0;
         r_err     <= 1'b0;
         r_wr      <= '0;
         r_rd      <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], a_tog};
         r_q    <= w_sync;
         if (w_push) begin
            r_wr      <= r_wr + 1'b1;
            r_ack     <= ~r_ack;
            r_pending <= 1'b0;
         end else if (w_req) begin
            r_pending <= 1'b1;
         end
         // A second request while one is held is dropped; only the held word is ever captured.
         if (w_en && r_pending)
            r_err <= 1'b1;
         if (w_pop)
            r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge bclk or posedge brst) begin
      if (brst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr[AW-1:0]] <= adata;
      end
   end

   assign bdata  = r_mem[r_rd[AW-1:0]];
   assign bvalid = !w_empty;
   assign bcount = r_wr - r_rd;
   assign b_ack  = r_ack;
   assign b_busy = r_pending;
   assign b_err  = r_err;

endmodule

// File: tb/tb_bmcp_recv_fifo.sv
// Directed bench for bmcp_recv_fifo: vector table on the default build, hand sequences for
// mid-operation reset and a wide/deep/3-stage build.
module tb_bmcp_recv_fifo;

   logic        bclk = 1'b0;
   logic        brst = 1'b1;
   logic        a_tog = 1'b0;
   logic [7:0]  adata = 8'h00;
   logic        bready = 1'b0;
   logic        b_ack, bvalid, b_busy, b_err;
   logic [7:0]  bdata;
   logic [2:0]  bcount;

   logic        a_tog2 = 1'b0;
   logic [15:0] adata2 = 16'h0000;
   logic        bready2 = 1'b0;
   logic        b_ack2, bvalid2, b_busy2, b_err2;
   logic [15:0] bdata2;
   logic [3:0]  bcount2;

   int checks = 0;
   int failures = 0;

   always #5 bclk = ~bclk;

   bmcp_recv_fifo u_dut (
      .bclk(bclk), .brst(brst), .a_tog(a_tog), .adata(adata), .b_ack(b_ack),
      .bdata(bdata), .bvalid(bvalid), .bready(bready), .bcount(bcount),
      .b_busy(b_busy), .b_err(b_err)
   );

   bmcp_recv_fifo #(.DW(16), .DEPTH(8), .SYNC_STAGES(3)) u_wide (
      .bclk(bclk), .brst(brst), .a_tog(a_tog2), .adata(adata2), .b_ack(b_ack2),
      .bdata(bdata2), .bvalid(bvalid2), .bready(bready2), .bcount(bcount2),
      .b_busy(b_busy2), .b_err(b_err2)
   );

   typedef struct packed {
      logic       tog;
      logic [7:0] data;
      logic       rdy;
      logic [3:0] cyc;
      logic       e_ack;
      logic       e_valid;
      logic [7:0] e_data;
      logic [2:0] e_cnt;
      logic       e_busy;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic tog, input logic [7:0] data, input logic rdy,
                               input logic [3:0] cyc, input logic e_ack, input logic e_valid,
                               input logic [7:0] e_data, input logic [2:0] e_cnt,
                               input logic e_busy, input logic e_err);
      vec_t v;
      v.tog = tog; v.data = data; v.rdy = rdy; v.cyc = cyc;
      v.e_ack = e_ack; v.e_valid = e_valid; v.e_data = e_data;
      v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Inputs change just after a falling edge; outputs are sampled at the falling edge after cyc rising edges.
   task automatic drive(input logic tog, input logic [7:0] data, input logic rdy, input int cyc);
      if (tog) a_tog = ~a_tog;
      adata  = data;
      bready = rdy;
      repeat (cyc) @(posedge bclk);
      @(negedge bclk);
   endtask

   task automatic drive2(input logic [15:0] data, input int cyc);
      a_tog2 = ~a_tog2;
      adata2 = data;
      repeat (cyc) @(posedge bclk);
      @(negedge bclk);
   endtask

   task automatic chk_all(input string tag, input logic e_ack, input logic e_valid,
                          input logic [7:0] e_data, input logic [2:0] e_cnt,
                          input logic e_busy, input logic e_err);
      chk({tag, ".b_ack"},  b_ack,  e_ack);
      chk({tag, ".bvalid"}, bvalid, e_valid);
      chk({tag, ".bdata"},  bdata,  e_data);
      chk({tag, ".bcount"}, bcount, e_cnt);
      chk({tag, ".b_busy"}, b_busy, e_busy);
      chk({tag, ".b_err"},  b_err,  e_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // single word and ack latency
      vecs.push_back(mk(1, 8'hA5, 0, 2, 0, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 8'hA5, 0, 1, 1, 1, 8'hA5, 1, 0, 0));
      vecs.push_back(mk(0, 8'hA5, 1, 1, 1, 0, 8'h00, 0, 0, 0));
      // fill, fifth word waits for space
      vecs.push_back(mk(1, 8'h01, 0, 3, 0, 1, 8'h01, 1, 0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 3, 1, 1, 8'h01, 2, 0, 0));
      vecs.push_back(mk(1, 8'h03, 0, 3, 0, 1, 8'h01, 3, 0, 0));
      vecs.push_back(mk(1, 8'h04, 0, 3, 1, 1, 8'h01, 4, 0, 0));
      vecs.push_back(mk(1, 8'h05, 0, 3, 1, 1, 8'h01, 4, 1, 0));
      vecs.push_back(mk(0, 8'h05, 1, 1, 0, 1, 8'h02, 4, 0, 0));
      // drain in order
      vecs.push_back(mk(0, 8'h05, 1, 1, 0, 1, 8'h03, 3, 0, 0));
      vecs.push_back(mk(0, 8'h05, 1, 1, 0, 1, 8'h04, 2, 0, 0));
      vecs.push_back(mk(0, 8'h05, 1, 1, 0, 1, 8'h05, 1, 0, 0));
      vecs.push_back(mk(0, 8'h05, 1, 1, 0, 0, 8'h02, 0, 0, 0));
      // streaming across pointer wrap
      vecs.push_back(mk(1, 8'h06, 1, 3, 1, 1, 8'h06, 1, 0, 0));
      vecs.push_back(mk(1, 8'h07, 1, 3, 0, 1, 8'h07, 1, 0, 0));
      vecs.push_back(mk(1, 8'h08, 1, 3, 1, 1, 8'h08, 1, 0, 0));
      vecs.push_back(mk(1, 8'h09, 1, 3, 0, 1, 8'h09, 1, 0, 0));
      vecs.push_back(mk(0, 8'h09, 1, 1, 0, 0, 8'h06, 0, 0, 0));
      // protocol error while pending
      vecs.push_back(mk(1, 8'h11, 0, 3, 1, 1, 8'h11, 1, 0, 0));
      vecs.push_back(mk(1, 8'h12, 0, 3, 0, 1, 8'h11, 2, 0, 0));
      vecs.push_back(mk(1, 8'h13, 0, 3, 1, 1, 8'h11, 3, 0, 0));
      vecs.push_back(mk(1, 8'h14, 0, 3, 0, 1, 8'h11, 4, 0, 0));
      vecs.push_back(mk(1, 8'h15, 0, 3, 0, 1, 8'h11, 4, 1, 0));
      vecs.push_back(mk(1, 8'h15, 0, 3, 0, 1, 8'h11, 4, 1, 1));
      vecs.push_back(mk(0, 8'h15, 1, 1, 1, 1, 8'h12, 4, 0, 1));
      vecs.push_back(mk(0, 8'h15, 0, 4, 1, 1, 8'h12, 4, 0, 1));
      vecs.push_back(mk(0, 8'h15, 1, 3, 1, 1, 8'h15, 1, 0, 1));
      vecs.push_back(mk(0, 8'h15, 1, 1, 1, 0, 8'h12, 0, 0, 1));

      // reset state
      repeat (2) @(negedge bclk);
      chk_all("reset", 0, 0, 8'h00, 0, 0, 0);
      chk("reset.wide_bcount", bcount2, 0);
      brst = 1'b0;
      @(negedge bclk);

      foreach (vecs[i]) begin
         drive(vecs[i].tog, vecs[i].data, vecs[i].rdy, int'(vecs[i].cyc));
         $display("vec %0d: tog=%0b adata=%02h bready=%0b -> ack=%0b valid=%0b bdata=%02h count=%0d busy=%0b err=%0b",
                  i, vecs[i].tog, vecs[i].data, vecs[i].rdy, b_ack, bvalid, bdata, bcount, b_busy, b_err);
         chk_all($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_valid, vecs[i].e_data,
                 vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_err);
      end

      // async reset with a full FIFO and a pending word
      drive(1, 8'h21, 0, 3);
      drive(1, 8'h22, 0, 3);
      drive(1, 8'h23, 0, 3);
      chk("midrst.pre_bcount3", bcount, 3);
      drive(1, 8'h24, 0, 3);
      drive(1, 8'h25, 0, 3);
      chk("midrst.pre_busy", b_busy, 1);
      #2;
      brst  = 1'b1;
      a_tog = 1'b0;
      #1;
      $display("midrst: ack=%0b valid=%0b bdata=%02h count=%0d busy=%0b err=%0b",
               b_ack, bvalid, bdata, bcount, b_busy, b_err);
      chk_all("midrst", 0, 0, 8'h00, 0, 0, 0);
      @(negedge bclk);
      brst = 1'b0;
      @(negedge bclk);
      drive(1, 8'h3C, 0, 3);
      $display("postrst: ack=%0b valid=%0b bdata=%02h count=%0d", b_ack, bvalid, bdata, bcount);
      chk_all("postrst", 1, 1, 8'h3C, 1, 0, 0);

      // wide build: 3 sync stages, 8 entries
      drive2(16'hBEEF, 3);
      chk("wide.ack_at3", b_ack2, 0);
      chk("wide.valid_at3", bvalid2, 0);
      repeat (1) @(posedge bclk);
      @(negedge bclk);
      $display("wide: ack=%0b valid=%0b bdata=%04h count=%0d", b_ack2, bvalid2, bdata2, bcount2);
      chk("wide.ack_at4", b_ack2, 1);
      chk("wide.valid", bvalid2, 1);
      chk("wide.bdata", bdata2, 16'hBEEF);
      chk("wide.bcount1", bcount2, 1);
      for (int k = 1; k < 8; k++) begin
         drive2(16'h1000 + 16'(k), 4);
         $display("wide word %0d: ack=%0b count=%0d busy=%0b", k, b_ack2, bcount2, b_busy2);
      end
      chk("wide.bcount8", bcount2, 8);
      chk("wide.busy_full", b_busy2, 0);
      chk("wide.ack8", b_ack2, 0);
      drive2(16'h2000, 4);
      chk("wide.busy_over", b_busy2, 1);
      chk("wide.ack_held", b_ack2, 0);
      chk("wide.bcount_held", bcount2, 8);
      chk("wide.head", bdata2, 16'hBEEF);
      chk("wide.err", b_err2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
